// File: rtl/display_framebuffer_pkg.sv
// Shared constants, state encoding and the pixel read-modify-write operator
// for the 128x64 page-layout framebuffer.
package display_framebuffer_pkg;

    localparam logic [1:0] FB_OP_NOP    = 2'b00;
    localparam logic [1:0] FB_OP_SET    = 2'b01;
    localparam logic [1:0] FB_OP_CLEAR  = 2'b10;
    localparam logic [1:0] FB_OP_TOGGLE = 2'b11;

    localparam int FB_PAGES   = 8;
    localparam int FB_COLUMNS = 128;
    localparam int FB_ADDR_W  = 10;
    localparam int FB_DEPTH   = FB_PAGES * FB_COLUMNS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_READ,
        ST_WR_MOD,
        ST_CLEAR
    } fb_state_t;

    function automatic logic [7:0] fb_apply_op(input logic [7:0] data,
                                               input logic [7:0] mask,
                                               input logic [1:0] op);
        logic [7:0] result;
        case (op)
            FB_OP_SET:    result = data | mask;
            FB_OP_CLEAR:  result = data & ~mask;
            FB_OP_TOGGLE: result = data ^ mask;
            default:      result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/display_fb_ram.sv
// 1024x8 simple dual-port memory: one write port, one registered read port.
// Read-first on a same-address collision; contents are not reset.
module display_fb_ram
    import display_framebuffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [FB_ADDR_W-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [FB_ADDR_W-1:0] raddr,
    output logic [7:0]           q
);

    logic [7:0] mem [FB_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/display_framebuffer.sv
// 128x64 1-bpp framebuffer: pixel RMW port, bulk clear, refresh read port.
// Optional DISPLAY_FB_CLEAR_ON_RESET_EN: run a full clear right after reset.
//
// state      | meaning
// IDLE       | accepting pixel writes, or starting a requested clear
// WR_READ    | fetch target byte when the refresh port leaves the RAM free
// WR_MOD     | apply op to the fetched byte and write it back
// CLEAR      | sweep CLEAR_BYTE over every address, one per cycle
module display_framebuffer
    import display_framebuffer_pkg::*;
#(
    parameter logic [7:0] CLEAR_BYTE = 8'h00
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_x,
    input  logic [5:0] wr_y,
    input  logic [1:0] wr_op,
    input  logic       clear_req,
    output logic       clear_busy,
    input  logic       rd_en,
    input  logic [2:0] rd_page,
    input  logic [6:0] rd_column,
    output logic [7:0] rd_byte,
    output logic       rd_valid
);

`ifdef DISPLAY_FB_CLEAR_ON_RESET_EN
    localparam logic PEND_AT_RESET = 1'b1;
`else
    localparam logic PEND_AT_RESET = 1'b0;
`endif
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_DEPTH - 1);

    fb_state_t            state, state_nxt;
    logic                 pend_q, pend_nxt;
    logic                 run;
    logic [6:0]           x_q;
    logic [5:0]           y_q;
    logic [1:0]           op_q;
    logic [FB_ADDR_W-1:0] clr_cnt;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [7:0]           mask;
    logic                 ram_we;
    logic [FB_ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [7:0]           ram_wdata, ram_q;

    assign wr_addr = {y_q[5:3], x_q};
    assign mask    = 8'b1 << y_q[2:0];

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend_q;
        wr_ready   = 1'b0;
        clear_busy = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = fb_apply_op(ram_q, mask, op_q);
        // refresh reads always own the shared read port
        ram_raddr  = rd_en ? {rd_page, rd_column} : wr_addr;
        case (state)
            ST_IDLE: begin
                wr_ready = run && !clear_req && !pend_q;
                if (clear_req || pend_q) begin
                    state_nxt = ST_CLEAR;
                end else if (wr_valid && wr_ready && wr_op != FB_OP_NOP) begin
                    state_nxt = ST_WR_READ;
                end
            end
            ST_WR_READ: begin
                pend_nxt = pend_q | clear_req;
                if (!rd_en) begin
                    state_nxt = ST_WR_MOD;
                end
            end
            ST_WR_MOD: begin
                ram_we    = 1'b1;
                state_nxt = (pend_q || clear_req) ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                clear_busy = 1'b1;
                pend_nxt   = 1'b0;
                ram_we     = 1'b1;
                ram_waddr  = clr_cnt;
                ram_wdata  = CLEAR_BYTE;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pend_q   <= PEND_AT_RESET;
            run      <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= FB_OP_NOP;
            clr_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_q   <= pend_nxt;
            run      <= 1'b1;
            rd_valid <= rd_en;
            if (state == ST_IDLE && wr_valid && wr_ready) begin
                x_q  <= wr_x;
                y_q  <= wr_y;
                op_q <= wr_op;
            end
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // RAM output register doubles as the read data register; mask it outside valid cycles
    assign rd_byte = rd_valid ? ram_q : 8'h00;

    display_fb_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .q     (ram_q)
    );

endmodule
